// File: rtl/key_schedule_ctrl_if.sv
// key_schedule_ctrl_if: groups the key loader handshake, the round-key read port and the
// key_schedule datapath link into one bundle.
// The master modport is the environment side; the slave modport is the controller side.
interface key_schedule_ctrl_if #(
    parameter int unsigned BLOCK_SIZE = 64,
    parameter int unsigned KEY_SIZE   = 128
);
    logic [KEY_SIZE-1:0]   key_in;
    logic                  key_valid;
    logic                  key_ready;
    logic                  keys_valid;
    logic                  busy;
    logic [4:0]            rd_addr;
    logic [BLOCK_SIZE-1:0] rd_data;
    logic [KEY_SIZE-1:0]   ks_key;
    logic [BLOCK_SIZE-1:0] ks_round_ctr;
    logic                  ks_start;
    logic                  ks_finished;
    logic [KEY_SIZE-1:0]   ks_out_key;
    logic                  error;

    modport master (
        output key_in, key_valid, rd_addr, ks_finished, ks_out_key,
        input  key_ready, keys_valid, busy, rd_data, ks_key, ks_round_ctr, ks_start, error
    );

    modport slave (
        input  key_in, key_valid, rd_addr, ks_finished, ks_out_key,
        output key_ready, keys_valid, busy, rd_data, ks_key, ks_round_ctr, ks_start, error
    );
endinterface

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: drives the external key_schedule datapath for NR_ROUNDS-1 calls,
// feeding each output key back as the next input, and stores every k0 subkey in a
// round-key buffer served through a registered read port.
// Optional watchdog on each schedule call: define KEY_CTRL_TIMEOUT_EN.
module key_schedule_ctrl #(
    parameter int unsigned BLOCK_SIZE     = 64,
    parameter int unsigned KEY_SIZE       = 128,
    parameter int unsigned NR_ROUNDS      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    key_schedule_ctrl_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NR_ROUNDS);

    if (KEY_SIZE != 2 * BLOCK_SIZE || NR_ROUNDS < 2 || NR_ROUNDS > 32 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("key_schedule_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StStore,
        StDone,
        StError
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [KEY_SIZE-1:0]   r_ks_key;
    logic [KEY_SIZE-1:0]   w_key_nxt;
    logic [IdxW-1:0]       r_ctr;
    logic [IdxW-1:0]       w_ctr_nxt;
    logic                  r_fin_prev;
    logic [BLOCK_SIZE-1:0] r_rd_data;
    logic [BLOCK_SIZE-1:0] r_rk [NR_ROUNDS];

    logic                  w_key_ready;
    logic                  w_accept;
    logic                  w_fin_rise;
    logic                  w_timeout;
    logic                  w_addr_ok;
    logic                  w_rk_we;
    logic [IdxW-1:0]       w_rk_waddr;
    logic [BLOCK_SIZE-1:0] w_rk_wdata;

    assign w_key_ready = (r_state == StIdle) || (r_state == StDone) || (r_state == StError);
    assign w_accept    = bus.key_valid && w_key_ready;
    // Only a fresh 0->1 transition of finished completes a call; a stuck-high level does not.
    assign w_fin_rise  = bus.ks_finished && !r_fin_prev;

    // A 5-bit address cannot exceed a full 32-entry buffer.
    if (NR_ROUNDS >= 32) begin : g_addr_full
        assign w_addr_ok = 1'b1;
    end else begin : g_addr_part
        assign w_addr_ok = (bus.rd_addr < 5'(NR_ROUNDS));
    end

`ifdef KEY_CTRL_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WdW-1:0] r_wd_cnt;

    // Watchdog counts WAIT cycles; cleared while in START so it restarts on each WAIT entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt <= '0;
        end else if (r_state == StStart) begin
            r_wd_cnt <= '0;
        end else if (r_state == StWait) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_wd_cnt == WdW'(TIMEOUT_CYCLES - 1));
    assign bus.error = (r_state == StError);
`else
    assign w_timeout = 1'b0;
    assign bus.error = 1'b0;
`endif

    // Next-state, next key/round counter and round-key buffer write decode.
    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_ks_key;
        w_ctr_nxt   = r_ctr;
        w_rk_we     = 1'b0;
        w_rk_waddr  = '0;
        w_rk_wdata  = '0;
        unique case (r_state)
            StIdle, StDone, StError: begin
                if (w_accept) begin
                    w_rk_we     = 1'b1;
                    w_rk_waddr  = '0;
                    w_rk_wdata  = bus.key_in[BLOCK_SIZE-1:0];
                    w_key_nxt   = bus.key_in;
                    w_ctr_nxt   = '0;
                    w_state_nxt = StStart;
                end
            end
            StStart: begin
                w_state_nxt = StWait;
            end
            StWait: begin
                if (w_fin_rise) begin
                    w_state_nxt = StStore;
                end else if (w_timeout) begin
                    w_state_nxt = StError;
                end
            end
            StStore: begin
                w_rk_we    = 1'b1;
                w_rk_waddr = r_ctr + 1'b1;
                w_rk_wdata = bus.ks_out_key[BLOCK_SIZE-1:0];
                w_key_nxt  = bus.ks_out_key;
                if (r_ctr == IdxW'(NR_ROUNDS - 2)) begin
                    w_state_nxt = StDone;
                end else begin
                    w_ctr_nxt   = r_ctr + 1'b1;
                    w_state_nxt = StStart;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Controller state, schedule-call registers and finished-edge history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_ks_key   <= '0;
            r_ctr      <= '0;
            r_fin_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ks_key   <= w_key_nxt;
            r_ctr      <= w_ctr_nxt;
            r_fin_prev <= bus.ks_finished;
        end
    end

    // Round-key buffer; contents need no reset because keys_valid gates every read.
    always_ff @(posedge clk) begin
        if (w_rk_we) begin
            r_rk[w_rk_waddr] <= w_rk_wdata;
        end
    end

    // Registered read port; returns zero until the full key set is present.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if ((r_state == StDone) && w_addr_ok) begin
            r_rd_data <= r_rk[bus.rd_addr[IdxW-1:0]];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign bus.key_ready    = w_key_ready;
    assign bus.keys_valid   = (r_state == StDone);
    assign bus.busy         = (r_state == StStart) || (r_state == StWait) ||
                              (r_state == StStore);
    assign bus.ks_start     = (r_state == StStart);
    assign bus.ks_key       = r_ks_key;
    assign bus.ks_round_ctr = BLOCK_SIZE'(r_ctr);
    assign bus.rd_data      = r_rd_data;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl: directed bench for key_schedule_ctrl with a stub key_schedule
// returning {key[127:64], key[63:0] + round_ctr + 1} six WAIT cycles after each start.
module tb_key_schedule_ctrl;
    logic clk;
    logic reset_n;
    int   vectors    = 0;
    int   miscompares = 0;

    key_schedule_ctrl_if bus ();

    key_schedule_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub schedule: 0 = normal, 1 = finished stuck high, 2 = never finishes.
    int           stub_mode = 0;
    int           stub_cnt;
    logic         stub_fin;
    logic [127:0] stub_key;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stub_cnt <= 0;
            stub_fin <= 1'b0;
            stub_key <= '0;
        end else if (bus.ks_start) begin
            stub_cnt <= 1;
            stub_fin <= 1'b0;
            stub_key <= {bus.ks_key[127:64], bus.ks_key[63:0] + bus.ks_round_ctr + 64'd1};
        end else if (stub_cnt != 0) begin
            if (stub_cnt == 5) begin
                stub_fin <= 1'b1;
                stub_cnt <= 0;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    assign bus.ks_finished = (stub_mode == 1) ? 1'b1 : (stub_mode == 2) ? 1'b0 : stub_fin;
    assign bus.ks_out_key  = stub_key;

    task automatic check_vec(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Closed form of the stub chain: k0 of round key n is k0 + n(n+1)/2.
    function automatic logic [63:0] exp_rk(input logic [63:0] k0, input int n);
        return k0 + 64'(n * (n + 1) / 2);
    endfunction

    // Round-counter order monitor, enabled for the first load only.
    logic mon_en    = 1'b0;
    int   start_cnt = 0;
    always @(negedge clk) begin
        if (mon_en && bus.ks_start) begin
            check_vec("ks_round_ctr order", bus.ks_round_ctr, 128'(start_cnt));
            start_cnt <= start_cnt + 1;
        end
    end

    // Presents a key for one accept cycle; returns at the negedge after the accept edge.
    task automatic start_load(input logic [127:0] k);
        @(negedge clk);
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        check_vec("key_ready at accept", bus.key_ready, 1);
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    // Counts cycles from the accept cycle (cycle 0) until keys_valid is seen high.
    task automatic wait_done(input int budget, output int cycles);
        cycles = 1;
        while (!bus.keys_valid && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check_vec("keys_valid after load", bus.keys_valid, 1);
    endtask

    task automatic read_check(input string tag, input logic [4:0] addr,
                              input logic [63:0] exp);
        bus.rd_addr = addr;
        @(negedge clk);
        check_vec(tag, bus.rd_data, 128'(exp));
    endtask

    task automatic wait_round(input int r);
        int n = 0;
        while (bus.ks_round_ctr != 64'(r) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_vec("reached round", bus.ks_round_ctr, 128'(r));
    endtask

    localparam logic [127:0] K1 = 128'h0000_0000_0000_0000_0000_0000_0000_0100;
    localparam logic [127:0] K2 = 128'hDEAD_BEEF_CAFE_F00D_0000_0000_0000_1000;
    localparam logic [127:0] K3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    initial begin
        int   cycles;
        logic ready_seen;

        reset_n       = 1'b1;
        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rd_addr   = '0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        check_vec("rst key_ready", bus.key_ready, 1);
        check_vec("rst keys_valid", bus.keys_valid, 0);
        check_vec("rst busy", bus.busy, 0);
        check_vec("rst ks_start", bus.ks_start, 0);
        check_vec("rst ks_key", bus.ks_key, 0);
        check_vec("rst ks_round_ctr", bus.ks_round_ctr, 0);
        check_vec("rst rd_data", bus.rd_data, 0);
        check_vec("rst error", bus.error, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // First load with cycle count and round-counter order.
        mon_en = 1'b1;
        start_load(K1);
        check_vec("busy after accept", bus.busy, 1);
        check_vec("rd_data while busy", bus.rd_data, 0);
        wait_done(2000, cycles);
        mon_en = 1'b0;
        check_vec("load latency", 128'(cycles), 249);
        check_vec("ks_start count", 128'(start_cnt), 31);
        check_vec("busy at done", bus.busy, 0);
        check_vec("key_ready at done", bus.key_ready, 1);
        check_vec("final ks_round_ctr", bus.ks_round_ctr, 30);
        check_vec("final ks_key", bus.ks_key, 128'h2F0);
        read_check("rk0", 5'd0, 64'h100);
        read_check("rk1", 5'd1, 64'h101);
        read_check("rk31", 5'd31, 64'h2F0);
        read_check("rk31 hold", 5'd31, 64'h2F0);
        for (int i = 0; i < 32; i++) begin
            read_check("rk sweep", 5'(i), exp_rk(64'h100, i));
        end

        // Read coinciding with reload returns the old key; then reads go to zero.
        bus.rd_addr = 5'd31;
        start_load(K2);
        check_vec("read at reload edge", bus.rd_data, 128'h2F0);
        check_vec("keys_valid drop", bus.keys_valid, 0);
        @(negedge clk);
        check_vec("read after reload", bus.rd_data, 0);

        // A different key offered at round 10 must be ignored.
        wait_round(10);
        ready_seen    = 1'b0;
        bus.key_in    = K3;
        bus.key_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ready_seen = ready_seen | bus.key_ready;
        end
        bus.key_valid = 1'b0;
        wait_done(2000, cycles);
        check_vec("key_ready low while busy", ready_seen, 0);
        check_vec("ignored load ks_key", bus.ks_key, {K2[127:64], 64'h11F0});
        read_check("K2 rk10", 5'd10, 64'h1037);
        read_check("K2 rk31", 5'd31, 64'h11F0);

        // Stuck-high finished must stall the controller in WAIT.
        stub_mode = 1;
        start_load(K1);
        repeat (40) @(negedge clk);
        check_vec("stall busy", bus.busy, 1);
        check_vec("stall keys_valid", bus.keys_valid, 0);
        check_vec("stall round_ctr", bus.ks_round_ctr, 0);
        check_vec("stall ks_start", bus.ks_start, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        stub_mode = 0;
        @(negedge clk);

        // Asynchronous reset during round 15, then a clean reload.
        start_load(K1);
        wait_round(15);
        #3 reset_n = 1'b0;
        #1;
        check_vec("midrst key_ready", bus.key_ready, 1);
        check_vec("midrst keys_valid", bus.keys_valid, 0);
        check_vec("midrst busy", bus.busy, 0);
        check_vec("midrst ks_start", bus.ks_start, 0);
        check_vec("midrst ks_key", bus.ks_key, 0);
        check_vec("midrst ks_round_ctr", bus.ks_round_ctr, 0);
        check_vec("midrst rd_data", bus.rd_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_load(K1);
        wait_done(2000, cycles);
        check_vec("reload latency", 128'(cycles), 249);
        read_check("reload rk31", 5'd31, 64'h2F0);
        read_check("reload rk5", 5'd5, 64'h10F);

`ifdef KEY_CTRL_TIMEOUT_EN
        // Never-finishing schedule: 1 START cycle plus 64 WAIT cycles, then ERROR.
        stub_mode = 2;
        start_load(K1);
        cycles = 1;
        while (!bus.error && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        check_vec("timeout error", bus.error, 1);
        check_vec("timeout latency", 128'(cycles), 65);
        check_vec("timeout keys_valid", bus.keys_valid, 0);
        check_vec("timeout busy", bus.busy, 0);
        check_vec("timeout key_ready", bus.key_ready, 1);
        stub_mode = 0;
        start_load(K2);
        check_vec("error cleared by load", bus.error, 0);
        wait_done(2000, cycles);
        read_check("after timeout rk31", 5'd31, 64'h11F0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
- Sequencer for the key_schedule datapath. Accepts a 128-bit master key, drives key_schedule once per round with an incrementing round counter, and feeds each output key back as the next input.
- Captures every round subkey k0 into an internal round-key buffer and serves it to the encryption round datapath through a registered read port.
- Sits between the top-level key loader and the cipher core; the key_schedule instance lives outside this block, wired to the ks_* ports.

Parameters:
- BLOCK_SIZE, 64, word width; round-key width.
- KEY_SIZE, 128, master key width (2 x BLOCK_SIZE).
- NR_ROUNDS, 32, number of round keys stored.
- TIMEOUT_CYCLES, 64, watchdog limit per schedule call (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- key_in  in  KEY_SIZE  master key; [63:0]=k0, [127:64]=k1.
- key_valid  in  1  load request.
- key_ready  out  1  high in IDLE and DONE; load accepted when key_valid and key_ready are both high.
- keys_valid  out  1  all NR_ROUNDS round keys stored and readable.
- busy  out  1  expansion in progress.
- rd_addr  in  5  round-key index.
- rd_data  out  BLOCK_SIZE  round key, 1-cycle read latency.
- ks_key  out  KEY_SIZE  to key_schedule.key.
- ks_round_ctr  out  BLOCK_SIZE  to key_schedule.round_ctr.
- ks_start  out  1  to key_schedule.signal_start.
- ks_finished  in  1  from key_schedule.finished.
- ks_out_key  in  KEY_SIZE  from key_schedule.outKey.
- error  out  1  watchdog fired; tied 0 without the optional feature.

Behaviour:
- Reset (async, reset_n=0) clears all of the following: state=IDLE, key_ready=1, keys_valid=0, busy=0, ks_start=0, ks_key=0, ks_round_ctr=0, rd_data=0, error=0, round index=0, finished-edge register=0. Buffer contents are don't-care. Reset mid-expansion aborts the expansion; keys_valid stays 0.
- IDLE: on key_valid&&key_ready, store rk[0]=key_in[63:0], set ks_key=key_in and ks_round_ctr=0, clear keys_valid, set busy; go to START.
- START: drive ks_start=1 for exactly one cycle; go to WAIT.
- WAIT: hold ks_key and ks_round_ctr stable. Detect the rising edge of ks_finished (registered previous value). A level that is already high does not count. On the edge go to STORE.
- STORE: rk[ks_round_ctr+1]=ks_out_key[63:0]; ks_key=ks_out_key.
  - If ks_round_ctr==NR_ROUNDS-2, go to DONE.
  - Otherwise increment ks_round_ctr and go to START.
- DONE: keys_valid=1, busy=0, key_ready=1.
  - A new accepted load drops keys_valid on the next cycle and restarts as in IDLE.
- key_valid while busy is ignored and not queued.
- Schedule calls: NR_ROUNDS-1 (=31) calls, round_ctr 0..30.
- Load latency: per round, 1 (START) + L (schedule latency to finished edge) + 1 (STORE) cycles, plus 1 accept cycle. keys_valid rises the cycle after the final STORE.
- Read port:
  - rd_data <= keys_valid ? rk[rd_addr] : 0, registered.
  - rd_addr >= NR_ROUNDS returns 0.
  - A read in the same cycle as a load accept returns the old key only if keys_valid was high at that edge.
- round_ctr is zero-extended to BLOCK_SIZE. The buffer index never wraps because the last STORE writes index NR_ROUNDS-1.

Optional Feature:
- Macro KEY_CTRL_TIMEOUT_EN.
- Defined: a counter resets on entering WAIT. If TIMEOUT_CYCLES elapse without a ks_finished edge, the block sets error=1, busy=0, keys_valid=0 and goes to an ERROR state with key_ready=1. A new load clears error and restarts. Only reset or a load clears error.
- Undefined: no counter, error tied 0, and WAIT waits indefinitely.

Test Plan:
- Stub schedule returning {key[127:64], key[63:0]+round_ctr+1} with 6-cycle latency. Load K=0x...0000_0000_0000_0100 -> keys_valid rises. rd_addr=0 gives 0x100, rd_addr=1 gives 0x101, rd_addr=31 gives 0x100+0x1F0=0x2F0, rd_addr=31 one cycle later as well.
- Cycle check with L=6: keys_valid rises exactly 1+31*8=249 cycles after the accept edge. ks_start is seen 31 times, and ks_round_ctr runs 0..30 in order.
- Hold ks_finished high continuously from the stub -> no STORE without a rising edge; the controller stalls in WAIT.
- Assert key_valid with a different key at round 10 -> ignored. Final keys match the first key; key_ready stays 0 until DONE.
- Pulse reset_n low during round 15 -> all outputs at reset values immediately. A subsequent load completes correctly.
- KEY_CTRL_TIMEOUT_EN with the stub never finishing, TIMEOUT_CYCLES=64 -> error=1 after 64 WAIT cycles, keys_valid=0. A new load clears error and completes.
